// File: rtl/riscv_pkg.sv
// Shared decoder constants and load/store helper functions.
// Used by the decoder, the LSU controller and its load formatter.
package riscv_pkg;

    localparam logic [4:0] MEMOFF     = 5'b00000;
    localparam logic [4:0] LBYTE      = 5'b00001;
    localparam logic [4:0] LHALFWORD  = 5'b00010;
    localparam logic [4:0] LWORD      = 5'b00011;
    localparam logic [4:0] LBYTEU     = 5'b00100;
    localparam logic [4:0] LHALFWORDU = 5'b00101;
    localparam logic [4:0] SBYTE      = 5'b10110;
    localparam logic [4:0] SHALFWORD  = 5'b10111;
    localparam logic [4:0] SWORD      = 5'b11000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [2:0] BR_EQ  = 3'd0;
    localparam logic [2:0] BR_NE  = 3'd1;
    localparam logic [2:0] BR_LT  = 3'd4;
    localparam logic [2:0] BR_GE  = 3'd5;
    localparam logic [2:0] BR_LTU = 3'd6;
    localparam logic [2:0] BR_GEU = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    function automatic logic is_legal_op(input logic [4:0] op);
        logic legal;
        case (op)
            LBYTE, LHALFWORD, LWORD, LBYTEU, LHALFWORDU,
            SBYTE, SHALFWORD, SWORD: legal = 1'b1;
            default:                 legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic is_store_op(input logic [4:0] op);
        return (op == SBYTE) || (op == SHALFWORD) || (op == SWORD);
    endfunction

    // Byte accesses can never be misaligned, so they fall into the default.
    function automatic logic is_aligned(input logic [4:0] op, input logic [1:0] lo);
        logic ok;
        case (op)
            LHALFWORD, LHALFWORDU, SHALFWORD: ok = (lo[0] == 1'b0);
            LWORD, SWORD:                     ok = (lo == 2'b00);
            default:                          ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [4:0] op, input logic [1:0] lo);
        logic [3:0] be;
        case (op)
            LBYTE, LBYTEU, SBYTE:             be = 4'b0001 << lo;
            LHALFWORD, LHALFWORDU, SHALFWORD: be = lo[1] ? 4'b1100 : 4'b0011;
            LWORD, SWORD:                     be = 4'b1111;
            default:                          be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] replicate_store(input logic [4:0] op, input logic [31:0] data);
        logic [31:0] rep;
        case (op)
            SBYTE:     rep = {4{data[7:0]}};
            SHALFWORD: rep = {2{data[15:0]}};
            default:   rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/halfword lane of a bus read word and
// sign- or zero-extends it to 32 bits.
module load_formatter
    import riscv_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        byteLane = rdata_i[7:0];
        case (addr_i)
            2'd0:    byteLane = rdata_i[7:0];
            2'd1:    byteLane = rdata_i[15:8];
            2'd2:    byteLane = rdata_i[23:16];
            default: byteLane = rdata_i[31:24];
        endcase
        halfLane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        result_o = rdata_i;
        case (op_i)
            LBYTE:      result_o = {{24{byteLane[7]}}, byteLane};
            LBYTEU:     result_o = {24'd0, byteLane};
            LHALFWORD:  result_o = {{16{halfLane[15]}}, halfLane};
            LHALFWORDU: result_o = {16'd0, halfLane};
            default:    result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns mem_op into a req/ack bus transaction,
// formats load data and stalls the pipeline while the access is outstanding.
module lsu_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic [4:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] ld_data,
    output logic        lsu_done,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err
);

    lsu_state_t state_q, state_d;

    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            busReq_q, busReq_d;
    logic            busWe_q, busWe_d;
    logic [3:0]      busBe_q, busBe_d;
    logic [31:0]     busAddr_q, busAddr_d;
    logic [31:0]     busWdata_q, busWdata_d;
    logic [4:0]      op_q, op_d;
    logic [1:0]      addrLo_q, addrLo_d;
    logic [31:0]     ldData_q, ldData_d;
    logic            lsuDone_q, lsuDone_d;
    logic            misalign_q, misalign_d;
    logic            busErr_q, busErr_d;

    logic        inIdle;
    logic        legalOp;
    logic        alignedOp;
    logic        start;
    logic        misalignReq;
    logic        timeout;
    logic [31:0] fmtResult;

    assign inIdle      = (state_q == IDLE);
    assign legalOp     = is_legal_op(mem_op);
    assign alignedOp   = is_aligned(mem_op, addr[1:0]);
    assign start       = inIdle & lsu_valid & legalOp & alignedOp;
    assign misalignReq = inIdle & lsu_valid & legalOp & ~alignedOp;
    assign timeout     = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    load_formatter u_load_formatter (
        .op_i     (op_q),
        .addr_i   (addrLo_q),
        .rdata_i  (bus_rdata),
        .result_o (fmtResult)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An ack in the final WAIT cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WAIT;
            WAIT:    if (bus_ack || timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        busReq_d   = busReq_q;
        busWe_d    = busWe_q;
        busBe_d    = busBe_q;
        busAddr_d  = busAddr_q;
        busWdata_d = busWdata_q;
        op_d       = op_q;
        addrLo_d   = addrLo_q;
        ldData_d   = ldData_q;
        lsuDone_d  = 1'b0;
        misalign_d = 1'b0;
        busErr_d   = 1'b0;
        stall      = 1'b0;
        case (state_q)
            IDLE: begin
                misalign_d = misalignReq;
                if (start) begin
                    stall      = 1'b1;
                    busReq_d   = 1'b1;
                    busWe_d    = is_store_op(mem_op);
                    busBe_d    = byte_enables(mem_op, addr[1:0]);
                    busAddr_d  = {addr[31:2], 2'b00};
                    busWdata_d = replicate_store(mem_op, wdata);
                    op_d       = mem_op;
                    addrLo_d   = addr[1:0];
                end
            end
            WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + TO_W'(1);
                if (bus_ack) begin
                    busReq_d  = 1'b0;
                    lsuDone_d = 1'b1;
                    if (!busWe_q) ldData_d = fmtResult;
                end else if (timeout) begin
                    busReq_d  = 1'b0;
                    lsuDone_d = 1'b1;
                    busErr_d  = 1'b1;
                    ldData_d  = 32'd0;
                end
            end
            DONE: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            busReq_q   <= 1'b0;
            busWe_q    <= 1'b0;
            busBe_q    <= 4'd0;
            busAddr_q  <= 32'd0;
            busWdata_q <= 32'd0;
            op_q       <= MEMOFF;
            addrLo_q   <= 2'd0;
            ldData_q   <= 32'd0;
            lsuDone_q  <= 1'b0;
            misalign_q <= 1'b0;
            busErr_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            busReq_q   <= busReq_d;
            busWe_q    <= busWe_d;
            busBe_q    <= busBe_d;
            busAddr_q  <= busAddr_d;
            busWdata_q <= busWdata_d;
            op_q       <= op_d;
            addrLo_q   <= addrLo_d;
            ldData_q   <= ldData_d;
            lsuDone_q  <= lsuDone_d;
            misalign_q <= misalign_d;
            busErr_q   <= busErr_d;
        end
    end

    assign bus_req   = busReq_q;
    assign bus_we    = busWe_q;
    assign bus_be    = busBe_q;
    assign bus_addr  = busAddr_q;
    assign bus_wdata = busWdata_q;
    assign ld_data   = ldData_q;
    assign lsu_done  = lsuDone_q;
    assign misalign  = misalign_q;
    assign bus_err   = busErr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized accesses
// checked against a transaction-level reference model.
module tb_lsu_ctrl;

    localparam int TIMEOUT = 4;

    localparam logic [4:0] OP_OFF = 5'b00000;
    localparam logic [4:0] OP_LB  = 5'b00001;
    localparam logic [4:0] OP_LH  = 5'b00010;
    localparam logic [4:0] OP_LW  = 5'b00011;
    localparam logic [4:0] OP_LBU = 5'b00100;
    localparam logic [4:0] OP_LHU = 5'b00101;
    localparam logic [4:0] OP_SB  = 5'b10110;
    localparam logic [4:0] OP_SH  = 5'b10111;
    localparam logic [4:0] OP_SW  = 5'b11000;

    logic        clk;
    logic        rst;
    logic        lsu_valid;
    logic [4:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [31:0] ld_data;
    logic        lsu_done;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    int          vectors;
    int          miscompares;
    logic [31:0] ldExp;

    lsu_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .lsu_valid (lsu_valid),
        .mem_op    (mem_op),
        .addr      (addr),
        .wdata     (wdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_be    (bus_be),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .ld_data   (ld_data),
        .lsu_done  (lsu_done),
        .stall     (stall),
        .misalign  (misalign),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic modelLegal(input logic [4:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic modelStore(input logic [4:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic int modelSize(input logic [4:0] op);
        if (op inside {OP_LW, OP_SW}) return 4;
        if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
        return 1;
    endfunction

    function automatic logic [3:0] modelBe(input logic [4:0] op, input logic [31:0] a);
        int sz = modelSize(op);
        int first = int'(a % 4);
        if (sz == 4) return 4'hF;
        if (sz == 2) return (first >= 2) ? 4'hC : 4'h3;
        return 4'(1 << first);
    endfunction

    function automatic logic [31:0] modelWdata(input logic [4:0] op, input logic [31:0] w);
        if (op == OP_SB) return (w & 32'hFF) * 32'h01010101;
        if (op == OP_SH) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [4:0] op, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * (a % 4))) & 32'hFF;
        h = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (op)
            OP_LB:   return (b >= 128) ? b - 256 : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32768) ? h - 65536 : h;
            OP_LHU:  return h;
            default: return rd;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full access: drive in IDLE, hold ack off for ackDelay WAIT cycles.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] w,
                                 input int ackDelay, input logic [31:0] rd);
        logic legal;
        logic aligned;
        logic acked;
        legal   = modelLegal(op);
        aligned = ((a % modelSize(op)) == 0);
        acked   = 1'b0;
        @(negedge clk);
        mem_op = op; addr = a; wdata = w; lsu_valid = 1'b1;
        #1;
        if (!legal || !aligned) begin
            checkOutput("stall_noaccess", stall, 0);
            @(negedge clk);
            lsu_valid = 1'b0;
            #1;
            checkOutput("misalign_pulse", misalign, (legal && !aligned) ? 1 : 0);
            checkOutput("req_noaccess", bus_req, 0);
            checkOutput("stall_noaccess2", stall, 0);
            @(negedge clk);
            checkOutput("misalign_clear", misalign, 0);
            checkOutput("req_noaccess2", bus_req, 0);
            checkOutput("done_noaccess", lsu_done, 0);
            return;
        end
        checkOutput("stall_start", stall, 1);
        @(negedge clk);
        lsu_valid = 1'($urandom_range(0, 1));
        mem_op = 5'($urandom); addr = $urandom; wdata = $urandom;
        #1;
        checkOutput("bus_we", bus_we, modelStore(op));
        checkOutput("bus_be", bus_be, modelBe(op, a));
        checkOutput("bus_addr", bus_addr, a & 32'hFFFFFFFC);
        if (modelStore(op)) checkOutput("bus_wdata", bus_wdata, modelWdata(op, w));
        for (int c = 0; c < TIMEOUT; c++) begin
            checkOutput("req_wait", bus_req, 1);
            checkOutput("stall_wait", stall, 1);
            checkOutput("be_stable", bus_be, modelBe(op, a));
            checkOutput("done_wait", lsu_done, 0);
            if (c == ackDelay) begin
                bus_ack = 1'b1; bus_rdata = rd;
                @(negedge clk);
                bus_ack = 1'b0; bus_rdata = $urandom;
                acked = 1'b1;
                break;
            end
            bus_rdata = $urandom;
            @(negedge clk);
        end
        lsu_valid = 1'b0;
        #1;
        if (!acked) ldExp = 32'd0;
        else if (!modelStore(op)) ldExp = modelLoad(op, a, rd);
        checkOutput("done_pulse", lsu_done, 1);
        checkOutput("req_dropped", bus_req, 0);
        checkOutput("stall_done", stall, 0);
        checkOutput("bus_err", bus_err, acked ? 0 : 1);
        checkOutput("ld_data", ld_data, ldExp);
        @(negedge clk);
        checkOutput("done_clear", lsu_done, 0);
        checkOutput("err_clear", bus_err, 0);
        checkOutput("stall_idle", stall, 0);
        checkOutput("ld_hold", ld_data, ldExp);
    endtask

    initial begin
        vectors = 0; miscompares = 0; ldExp = 32'd0;
        rst = 1'b1; lsu_valid = 1'b0; mem_op = OP_OFF; addr = 32'd0; wdata = 32'd0;
        bus_rdata = 32'd0; bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req", bus_req, 0);
        checkOutput("rst_we", bus_we, 0);
        checkOutput("rst_be", bus_be, 0);
        checkOutput("rst_addr", bus_addr, 0);
        checkOutput("rst_wdata", bus_wdata, 0);
        checkOutput("rst_ld", ld_data, 0);
        checkOutput("rst_done", lsu_done, 0);
        checkOutput("rst_misalign", misalign, 0);
        checkOutput("rst_err", bus_err, 0);
        checkOutput("rst_stall", stall, 0);
        rst = 1'b0;

        $display("[TB] directed accesses");
        applyStimulus(OP_LW, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        applyStimulus(OP_LB, 32'h103, 32'h0, 0, 32'h80FF0000);
        applyStimulus(OP_LBU, 32'h103, 32'h0, 0, 32'h80FF0000);
        applyStimulus(OP_SH, 32'h202, 32'h1234ABCD, 1, 32'h0);
        applyStimulus(OP_LH, 32'h101, 32'h0, 0, 32'h0);
        applyStimulus(OP_SW, 32'h102, 32'h55AA55AA, 0, 32'h0);
        applyStimulus(OP_SW, 32'h300, 32'hCAFEF00D, TIMEOUT + 2, 32'h0);
        applyStimulus(OP_LHU, 32'h402, 32'h0, TIMEOUT - 1, 32'h80017FFE);
        applyStimulus(OP_LH, 32'h402, 32'h0, 2, 32'h80017FFE);
        applyStimulus(5'b11111, 32'h500, 32'h0, 0, 32'h0);

        $display("[TB] stray ack in IDLE");
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        checkOutput("idle_ack_done", lsu_done, 0);
        checkOutput("idle_ack_ld", ld_data, ldExp);
        checkOutput("idle_ack_req", bus_req, 0);

        $display("[TB] reset during WAIT");
        @(negedge clk);
        mem_op = OP_LW; addr = 32'h600; lsu_valid = 1'b1;
        @(negedge clk);
        lsu_valid = 1'b0;
        #1;
        checkOutput("pre_rst_req", bus_req, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ldExp = 32'd0;
        #1;
        checkOutput("mid_rst_req", bus_req, 0);
        checkOutput("mid_rst_stall", stall, 0);
        checkOutput("mid_rst_done", lsu_done, 0);
        applyStimulus(OP_LW, 32'h604, 32'h0, 0, 32'h0BADF00D);

        $display("[TB] randomized accesses");
        for (int i = 0; i < 60; i++) begin
            logic [4:0] op;
            case ($urandom_range(0, 9))
                0: op = OP_LB;  1: op = OP_LH;  2: op = OP_LW;
                3: op = OP_LBU; 4: op = OP_LHU; 5: op = OP_SB;
                6: op = OP_SH;  7: op = OP_SW;  8: op = OP_LW;
                default: op = 5'($urandom);
            endcase
            applyStimulus(op, $urandom, $urandom, $urandom_range(0, TIMEOUT + 1), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Executes the memory operation selected by the decoder's 5-bit mem_op code, which has no consumer yet.
- Converts each load/store into a req/ack data-bus transaction with byte enables and lane-replicated store data.
- Formats load data with sign or zero extension and stalls the pipeline while the transaction is outstanding.
- Sits in the execute/memory stage, between the ALU result (effective address), the rs2 value (store data) and the data memory.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT without bus_ack before bus_err.
- TO_W, $clog2(TIMEOUT_CYCLES+1): width of the timeout counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- lsu_valid  in  1  the instruction in this stage is valid.
- mem_op  in  5  decoder code: MEMOFF 00000, LBYTE 00001, LHALFWORD 00010, LWORD 00011, LBYTEU 00100, LHALFWORDU 00101, SBYTE 10110, SHALFWORD 10111, SWORD 11000.
- addr  in  32  effective address from the ALU.
- wdata  in  32  store data (rs2).
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = store.
- bus_be  out  4  byte enables.
- bus_addr  out  32  word-aligned address (addr[31:2], 2'b00).
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read data, valid when bus_ack = 1.
- bus_ack  in  1  transaction complete.
- ld_data  out  32  formatted load result.
- lsu_done  out  1  one-cycle completion pulse.
- stall  out  1  freeze the upstream pipeline.
- misalign  out  1  one-cycle misaligned-access pulse.
- bus_err  out  1  one-cycle timeout pulse.

Behaviour:
- Reset (sync): state = IDLE. All registered outputs are 0: bus_req, bus_we, bus_be, bus_addr, bus_wdata, ld_data, lsu_done, misalign, bus_err. Timeout counter = 0.
- Reset asserted mid-transaction: bus_req falls at the same edge; the pending access is abandoned.
- Legal op: one of the 8 non-MEMOFF codes listed under Ports. Any other code is treated as MEMOFF.
- start = lsu_valid & legal op & aligned, evaluated in IDLE only.
- Alignment rules:
  - Halfword ops require addr[0] = 0.
  - LWORD/SWORD require addr[1:0] = 00.
  - Byte ops are always aligned.
- States: IDLE, WAIT, DONE.
- IDLE, misaligned access (lsu_valid & legal op & misaligned): misalign = 1 on the next cycle for one cycle; no bus access; stay in IDLE; stall stays 0.
- IDLE, start:
  - Register the address, byte enables, we and replicated data; go to WAIT.
  - bus_req = 1 from the first WAIT cycle.
- WAIT:
  - bus_req, bus_we, bus_be, bus_addr and bus_wdata stay stable until the bus_ack cycle.
  - Timeout counter increments every cycle.
- WAIT, bus_ack = 1:
  - Capture the formatted bus_rdata into ld_data (loads only; stores leave ld_data unchanged).
  - Drop bus_req next cycle; go to DONE.
- WAIT, counter reaches TIMEOUT_CYCLES without ack:
  - Drop bus_req; bus_err = 1 for one cycle; ld_data = 0; go to DONE.
- bus_ack on the same cycle as the timeout: ack wins, no bus_err.
- DONE: lsu_done = 1 for one cycle; counter cleared; return to IDLE. A new start is accepted in the following IDLE cycle.
- stall (combinational) = (state == IDLE & start) | (state == WAIT). It is low in DONE.
- Minimum latency with bus_ack on the first WAIT cycle: start cycle, WAIT, DONE. That is 2 stall cycles, with lsu_done in the 3rd cycle.
- Byte enables:
  - Byte ops: be = 0001 << addr[1:0].
  - Halfword ops: be = 0011 (addr[1] = 0) or 1100 (addr[1] = 1).
  - Word ops: be = 1111.
  - Loads drive the same be pattern with bus_we = 0.
- Store data replication:
  - SBYTE: {4{wdata[7:0]}}.
  - SHALFWORD: {2{wdata[15:0]}}.
  - SWORD: wdata.
- Load formatting:
  - Select the byte lane by addr[1:0], or the half by addr[1].
  - LBYTE/LHALFWORD sign-extend; LBYTEU/LHALFWORDU zero-extend; LWORD passes the word through.
- bus_ack in IDLE or DONE is ignored.
- Inputs (lsu_valid, mem_op, addr, wdata) are ignored outside IDLE.

Decomposition:
- Shared package riscv_pkg holds:
  - the mem_op localparams (MEMOFF through SWORD) and the ALU/branch opcode constants, shared with the decoder;
  - an lsu_state_t enum (IDLE, WAIT, DONE).
- One combinational sub-module, load_formatter (inputs: op, addr[1:0], rdata; output: 32-bit result), handles lane select and extension.

Test Plan:
- LWORD, addr 0x100, bus_rdata 0xDEADBEEF, ack on the first WAIT cycle -> bus_be 1111, bus_we 0, ld_data 0xDEADBEEF, lsu_done in cycle 3, stall high for 2 cycles.
- LBYTE addr 0x103 and LBYTEU addr 0x103, rdata 0x80FF_0000 -> be 1000; ld_data 0xFFFFFF80 and 0x00000080 respectively.
- SHALFWORD addr 0x202, wdata 0x1234ABCD -> bus_we 1, be 1100, bus_wdata 0xABCDABCD, bus_addr 0x200.
- LHALFWORD addr 0x101 and SWORD addr 0x102 -> misalign pulses, bus_req never rises, stall stays 0.
- SWORD with ack withheld, TIMEOUT_CYCLES = 4 -> bus_req high exactly 4 cycles, then bus_err and lsu_done pulse, return to IDLE.
- rst asserted on the 2nd WAIT cycle -> bus_req 0 and state IDLE at the next edge; a following LWORD completes normally.
